// File: rtl/mmio_pkg.sv
// mmio_pkg: offset-map helpers and window base address shared by the mmio bridge
package mmio_pkg;
  localparam int IN_BASE = 0;
  function automatic int out_base(input int n_in);
    return IN_BASE + n_in;
  endfunction
  function automatic int stat_off(input int n_in, input int n_out);
    return IN_BASE + n_in + n_out;
  endfunction
  function automatic int window_base(input int aw, input int io_aw);
    return (1 << aw) - (1 << io_aw);
  endfunction
endpackage

// File: rtl/mmio_bridge_ce_gen.sv
// ce_gen: one-cycle enable every DIVISOR clocks, first pulse DIVISOR cycles after reset
module ce_gen #(
  parameter int DIVISOR = 2
) (
  input  logic clk,
  input  logic rst,
  output logic ce
);
  localparam int CW = DIVISOR > 1 ? $clog2(DIVISOR) : 1;
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(DIVISOR - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else begin
      cnt <= last ? '0 : cnt + 1'b1;
      ce  <= last;
    end
endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: CPU/memory bridge with an I/O window at the top of memory; MMIO_STATUS_EN adds a sticky input-change status word
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int N_IN       = 2,
  parameter int N_OUT      = 2,
  parameter int IO_AW      = 3,
  parameter int DIVISOR    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        cpu_ce,
  input  logic                        cpu_we,
  input  logic [ADDR_WIDTH-1:0]       cpu_addr,
  input  logic [DATA_WIDTH-1:0]       cpu_wdata,
  output logic [DATA_WIDTH-1:0]       cpu_rdata,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_data,
  input  logic [DATA_WIDTH-1:0]       mem_out,
  input  logic [N_IN*DATA_WIDTH-1:0]  in_bus,
  output logic [N_OUT*DATA_WIDTH-1:0] out_bus,
  output logic [N_OUT-1:0]            out_strobe
);
  localparam int OUT_B = out_base(N_IN);
`ifdef MMIO_STATUS_EN
  localparam int N_STAT = 1;
  localparam int STAT = stat_off(N_IN, N_OUT);
`else
  localparam int N_STAT = 0;
`endif
  localparam logic [ADDR_WIDTH-1:0] WBASE = ADDR_WIDTH'(window_base(ADDR_WIDTH, IO_AW));
  if (N_IN + N_OUT + N_STAT > (1 << IO_AW) || IO_AW >= ADDR_WIDTH) begin : g_chk
    $error("mmio_bridge: I/O window too small or wider than the address space");
  end
  ce_gen #(.DIVISOR(DIVISOR)) u_ce (.clk(clk), .rst(rst), .ce(cpu_ce));
  logic io_hit, wr, sel_q;
  logic [IO_AW-1:0] off;
  logic [DATA_WIDTH-1:0] io_d, io_q;
  logic [N_IN-1:0][DATA_WIDTH-1:0] s1, s2;
  logic [N_OUT-1:0][DATA_WIDTH-1:0] out_r;
  assign io_hit    = cpu_addr >= WBASE;
  assign off       = cpu_addr[IO_AW-1:0];
  assign wr        = cpu_ce & cpu_we & io_hit;
  assign mem_addr  = cpu_addr;
  assign mem_data  = cpu_wdata;
  assign mem_we    = cpu_we & cpu_ce & ~io_hit;
  assign out_bus   = out_r;
  assign cpu_rdata = sel_q ? io_q : mem_out;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_bus;
      s2 <= s1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_r      <= '0;
      out_strobe <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        out_strobe[j] <= wr && off == IO_AW'(OUT_B + j);
        if (wr && off == IO_AW'(OUT_B + j)) out_r[j] <= cpu_wdata;
      end
    end
`ifdef MMIO_STATUS_EN
  logic [N_IN-1:0][DATA_WIDTH-1:0] prev;
  logic [N_IN-1:0] flags, chg;
  logic rd_stat;
  assign rd_stat = cpu_ce & ~cpu_we & io_hit & (off == IO_AW'(STAT));
  always_comb
    for (int i = 0; i < N_IN; i++) chg[i] = s2[i] != prev[i];
  // a change in the clearing cycle re-sets its flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev  <= '0;
      flags <= '0;
    end else begin
      prev  <= s2;
      flags <= (rd_stat ? '0 : flags) | chg;
    end
`endif
  always_comb begin
    io_d = '0;
    for (int i = 0; i < N_IN; i++) if (off == IO_AW'(IN_BASE + i)) io_d = s2[i];
    for (int j = 0; j < N_OUT; j++) if (off == IO_AW'(OUT_B + j)) io_d = out_r[j];
`ifdef MMIO_STATUS_EN
    if (off == IO_AW'(STAT)) io_d = DATA_WIDTH'(flags);
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel_q <= 1'b0;
      io_q  <= '0;
    end else if (cpu_ce) begin
      sel_q <= io_hit;
      io_q  <= io_d;
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: scoreboard bench for mmio_bridge (DIVISOR=3) plus a DIVISOR=1 instance
module tb_mmio_bridge;
  localparam int AW = 6, DW = 16, NI = 2, NO = 2;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cpu_we = 0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] mem_out;
  logic [NI*DW-1:0] in_bus = '0;
  logic cpu_ce, mem_we, ce1, mem_we1;
  logic [DW-1:0] cpu_rdata, mem_data, rdata1, mem_data1;
  logic [AW-1:0] mem_addr, mem_addr1;
  logic [NO*DW-1:0] out_bus, out_bus1;
  logic [NO-1:0] out_strobe, out_strobe1;
  int checks = 0, errors = 0;
  int mem_we_cnt = 0, mem_we_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem [64];

  mmio_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_IN(NI), .N_OUT(NO), .IO_AW(3), .DIVISOR(3)) dut (
    .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_out(mem_out), .in_bus(in_bus), .out_bus(out_bus),
    .out_strobe(out_strobe));

  mmio_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_IN(NI), .N_OUT(NO), .IO_AW(3), .DIVISOR(1)) dut1 (
    .clk(clk), .rst(rst), .cpu_ce(ce1), .cpu_we(1'b0), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rdata1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_data(mem_data1), .mem_out(mem_out), .in_bus(in_bus), .out_bus(out_bus1),
    .out_strobe(out_strobe1));

  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= DW'(i * 3 + 1);
      mem_out <= '0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_data;
      mem_out <= mem[mem_addr];
    end

  always @(posedge clk)
    if (mem_we) begin
      mem_we_cnt++;
      if (!cpu_ce) mem_we_bad++;
    end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic wait_ce;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (cpu_ce) return;
    end
    checks++; errors++;
    $display("FAIL ce_timeout: no cpu_ce within 10 cycles");
  endtask

  task automatic access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ce;
    cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_we = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e, input string name);
    logic [DW-1:0] x;
    exp_q.push_back(e);
    access(0, a, '0);
    x = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== x) begin
      errors++;
      $display("FAIL %s: rdata got %h expected %h", name, cpu_rdata, x);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (cpu_ce !== 0 || ce1 !== 0 || out_bus !== '0 || out_strobe !== '0 || cpu_rdata !== mem_out) begin
      errors++;
      $display("FAIL reset_state: ce=%b ce1=%b out=%h strb=%b rdata=%h mem_out=%h",
               cpu_ce, ce1, out_bus, out_strobe, cpu_rdata, mem_out);
    end
    @(negedge clk) rst = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      checks++;
      if (cpu_ce !== (k % 3 == 0) || ce1 !== 1'b1) begin
        errors++;
        $display("FAIL ce_pattern cycle %0d: ce=%b expected %b, ce1=%b expected 1", k, cpu_ce, k % 3 == 0, ce1);
      end
    end
  endtask

  task automatic test_io_write;
    int c0;
    c0 = mem_we_cnt;
    access(1, 6'h3A, 16'h00AB);
    checks++;
    if (out_bus !== 32'h0000_00AB || out_strobe !== 2'b01) begin
      errors++;
      $display("FAIL io_write: out=%h strb=%b expected 000000ab 01", out_bus, out_strobe);
    end
    @(posedge clk); #1;
    checks++;
    if (out_strobe !== 2'b00 || mem_we_cnt != c0) begin
      errors++;
      $display("FAIL io_write_after: strb=%b expected 00, mem writes %0d expected %0d", out_strobe, mem_we_cnt, c0);
    end
  endtask

  task automatic test_mem_write;
    int c0;
    c0 = mem_we_cnt;
    access(1, 6'h05, 16'h1234);
    checks++;
    if (mem_we_cnt != c0 + 1 || mem_we_bad != 0 || out_bus !== 32'h0000_00AB || out_strobe !== 2'b00) begin
      errors++;
      $display("FAIL mem_write: writes %0d expected %0d, bad %0d, out=%h strb=%b",
               mem_we_cnt - c0, 1, mem_we_bad, out_bus, out_strobe);
    end
    rd(6'h05, 16'h1234, "mem_readback");
  endtask

  task automatic test_reads;
    in_bus = {16'h0009, 16'h0055};
    repeat (3) @(posedge clk);
    #1;
    rd(6'h39, 16'h0009, "read_in1");
    rd(6'h38, 16'h0055, "read_in0");
    rd(6'h3A, 16'h00AB, "read_out0");
    rd(6'h3F, 16'h0000, "read_unmapped");
    rd(6'h01, 16'h0004, "read_mem");
    access(1, 6'h38, 16'hFFFF);
    rd(6'h38, 16'h0055, "input_read_only");
`ifndef MMIO_STATUS_EN
    rd(6'h3C, 16'h0000, "status_off");
`endif
  endtask

  task automatic test_back_to_back;
    access(1, 6'h3A, 16'h1111);
    checks++;
    if (out_strobe !== 2'b01 || out_bus[15:0] !== 16'h1111) begin
      errors++;
      $display("FAIL b2b_first: strb=%b out=%h", out_strobe, out_bus);
    end
    access(1, 6'h3B, 16'h2222);
    checks++;
    if (out_strobe !== 2'b10 || out_bus !== 32'h2222_1111 || mem_we_bad != 0) begin
      errors++;
      $display("FAIL b2b_second: strb=%b out=%h expected 10 22221111, bad=%0d", out_strobe, out_bus, mem_we_bad);
    end
    rd(6'h3B, 16'h2222, "read_out1");
  endtask

`ifdef MMIO_STATUS_EN
  task automatic test_status;
    rd(6'h3C, 16'h0003, "status_initial");
    rd(6'h3C, 16'h0000, "status_cleared");
    in_bus[15:0] = in_bus[15:0] ^ 16'h0001;
    repeat (4) @(posedge clk);
    #1;
    rd(6'h3C, 16'h0001, "status_toggle");
    rd(6'h3C, 16'h0000, "status_toggle_cleared");
    wait_ce;
    @(posedge clk); #1;
    in_bus[15:0] = in_bus[15:0] ^ 16'h0001;
    rd(6'h3C, 16'h0000, "status_same_cycle_read");
    rd(6'h3C, 16'h0001, "status_set_wins");
  endtask
`endif

  task automatic test_reset_mid;
    int n;
    wait_ce;
    @(posedge clk); #1;
    cpu_we = 1; cpu_addr = 6'h3B; cpu_wdata = 16'hBEEF;
    #2 rst = 1;
    #1;
    checks++;
    if (out_bus !== '0 || out_strobe !== '0 || cpu_ce !== 0) begin
      errors++;
      $display("FAIL mid_reset: out=%h strb=%b ce=%b expected all 0", out_bus, out_strobe, cpu_ce);
    end
    cpu_we = 0;
    @(negedge clk) rst = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n++;
      if (cpu_ce) break;
    end
    checks++;
    if (n != 3 || out_bus !== '0) begin
      errors++;
      $display("FAIL mid_reset_restart: first ce after %0d cycles expected 3, out=%h", n, out_bus);
    end
  endtask

  task automatic test_div1;
    cpu_addr = 6'h01;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdata1 !== mem_out || mem_we1 !== 0 || out_bus1 !== '0 || out_strobe1 !== '0 ||
        mem_addr1 !== cpu_addr || mem_data1 !== cpu_wdata || ce1 !== 1) begin
      errors++;
      $display("FAIL div1_idle: rdata=%h/%h we=%b out=%h strb=%b addr=%h data=%h ce=%b",
               rdata1, mem_out, mem_we1, out_bus1, out_strobe1, mem_addr1, mem_data1, ce1);
    end
  endtask

  initial begin
    test_reset;
    test_io_write;
    test_mem_write;
    test_reads;
    test_back_to_back;
`ifdef MMIO_STATUS_EN
    test_status;
`endif
    test_reset_mid;
    test_div1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits between the CPU bus and the synchronous memory.
- Carves a memory-mapped I/O window out of the top of the address space. The window holds N_IN synchronised input channels and N_OUT output registers, which replace the fixed CPU input and output wiring.
- Contains a parametrised clock-enable generator that paces the CPU and memory from the single system clock, replacing the separate divided clock.

Parameters:
- ADDR_WIDTH, 6, CPU/memory address width.
- DATA_WIDTH, 16, data word width.
- N_IN, 2, number of input channels (>=1).
- N_OUT, 2, number of output registers (>=1).
- IO_AW, 3, address bits of the I/O window; window = top 2^IO_AW words.
- DIVISOR, 2, clk cycles per CPU step (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cpu_ce  out  1  one-cycle step enable to CPU/memory.
- cpu_we  in  1  CPU write request.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_rdata  out  DATA_WIDTH  read data returned to CPU.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_data  out  DATA_WIDTH  memory write data.
- mem_out  in  DATA_WIDTH  memory read data (1-cycle synchronous).
- in_bus  in  N_IN*DATA_WIDTH  external inputs; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_bus  out  N_OUT*DATA_WIDTH  output register contents.
- out_strobe  out  N_OUT  one-cycle pulse per output channel on write.

Behaviour:
- Reset values (async, rst=1):
  - Counter, out_bus, out_strobe, cpu_ce, synchronisers, read-select and read-data registers all 0.
  - cpu_rdata = mem_out while the select is 0.
- CE generator:
  - Counter 0..DIVISOR-1; cpu_ce=1 in the cycle where count==DIVISOR-1, then the count wraps to 0.
  - DIVISOR==1: cpu_ce=1 every cycle after reset release.
- Decode: io_hit = (cpu_addr[ADDR_WIDTH-1:IO_AW] all ones); off = cpu_addr[IO_AW-1:0].
- I/O offset map:
  - 0..N_IN-1: input channel, read-only.
  - N_IN..N_IN+N_OUT-1: output register, R/W.
  - Other offsets: read 0, writes ignored.
- Elaboration check: error if N_IN+N_OUT(+1 with status) > 2^IO_AW, or IO_AW >= ADDR_WIDTH.
- Memory pass-through (combinational):
  - mem_addr = cpu_addr; mem_data = cpu_wdata.
  - mem_we = cpu_we & cpu_ce & ~io_hit.
  - Writes into the window never reach memory.
- Writes: on a clk edge with cpu_ce & cpu_we & io_hit and off an output slot → that register loads cpu_wdata, and its out_strobe is 1 for exactly the next cycle. All other strobes are 0.
- Inputs: each channel passes through a 2-flop synchroniser on clk; reads return the synchronised value.
- Read latency: 1 step, matching memory.
  - On a cpu_ce edge, register sel_q<=io_hit and io_q<=decoded I/O data.
  - cpu_rdata = sel_q ? io_q : mem_out.
  - sel_q/io_q hold between enables.
- Mid-operation reset: counter restarts; an in-flight write is lost; the first cpu_ce occurs DIVISOR cycles after rst falls.

Optional Feature:
- Macro MMIO_STATUS_EN.
- Enabled:
  - Status word at offset N_IN+N_OUT. Bit i is a sticky flag, set when synchronised input i changes value (compared with its previous synchronised sample).
  - A read of the status word returns the flags and clears them on that cpu_ce edge; a change in the same cycle re-sets the flag (set wins).
  - Bits >= N_IN read 0.
- Disabled: no flag registers; that offset reads 0.

Decomposition:
- Shared package mmio_pkg:
  - Offset-map helper constants: IN_BASE=0, OUT_BASE=N_IN, STAT_OFF.
  - A localparam function computing the window base address.
- One natural sub-module: ce_gen (DIVISOR counter producing cpu_ce), reusable elsewhere.
- Synchroniser and decode stay inline.

Test Plan:
- DIVISOR=3, release reset → cpu_ce pulses at cycles 3,6,9 after rst falls; DIVISOR=1 → cpu_ce constant 1.
- Write 16'h00AB to addr 6'h3A (offset 2 = output 0 for IO_AW=3, N_IN=2) → out_bus[15:0]=00AB next cycle, out_strobe=2'b01 for one cycle, mem_we never asserted.
- Write 16'h1234 to addr 6'h05 → mem_we=1 only in the cpu_ce cycle; out_bus unchanged.
- in_bus channel1=16'h0009; read addr 6'h39 after >=2 cycles → cpu_rdata=0009 one step later. Read addr 6'h3F → 0000. Read addr 6'h01 → cpu_rdata=mem_out.
- With MMIO_STATUS_EN, toggle channel 0, read offset 4 → 16'h0001 and flag cleared. Toggle in the same cycle as the read → flag remains 1.
- Assert rst while an output write is pending with cpu_ce=0 → out_bus=0, strobe 0, counter restarted.
